// File: rtl/mem_burst_initiator.sv
`default_nettype none
// ============================================================================
// Module   : mem_burst_initiator
// Purpose  : Burst initiator for the word-indexed RAM helper port; read data
//            returns through a skid FIFO. Optional checks: MEM_BURST_INITIATOR_ASSERT_EN
// Revision : 1.0 - initial release
// ============================================================================
module mem_burst_initiator #(
    parameter int              LEN_W      = 8,
    parameter int              FIFO_DEPTH = 4,
    parameter longint unsigned MEM_WORDS  = 64'd536870912
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [63:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [63:0]      wdata,
    input  logic [7:0]       wstrb,
    output logic             rdata_valid,
    input  logic             rdata_ready,
    output logic [63:0]      rdata,
    output logic             rdata_last,
    output logic             done,
    output logic             err,
    output logic             mem_enable,
    output logic             mem_r_enable,
    output logic [63:0]      mem_r_index,
    input  logic [63:0]      mem_r_data,
    output logic             mem_w_enable,
    output logic [63:0]      mem_w_index,
    output logic [63:0]      mem_w_data,
    output logic [63:0]      mem_w_mask
);

    localparam int          c_ptr_w     = $clog2(FIFO_DEPTH);
    localparam int          c_cnt_w     = c_ptr_w + 1;
    localparam int          c_beat_w    = LEN_W + 1;
    localparam logic [64:0] c_mem_words = {1'b0, 64'(MEM_WORDS)};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_RDRAIN = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_en;
    logic [63:0]           r_base;
    logic [c_beat_w-1:0]   r_beats;
    logic [c_beat_w-1:0]   r_issued;
    logic [c_beat_w-1:0]   r_written;
    logic [c_beat_w-1:0]   r_popped;
    logic                  r_err;
    logic                  r_inflight;
    logic [63:0]           r_fifo [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;

    logic                  w_req_fire;
    logic [c_beat_w-1:0]   w_req_beats;
    logic [64:0]           w_base65;
    logic [64:0]           w_last65;
    logic                  w_range_ok;
    logic                  w_fifo_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_rd_issue;
    logic                  w_wr_fire;
    logic [c_beat_w-1:0]   w_popped_nxt;
    logic [c_beat_w-1:0]   w_beats_m1;
    logic [63:0]           w_mask;
    logic                  w_unused_addr_lsbs;

    assign w_unused_addr_lsbs = ^req_addr[2:0];

    assign req_ready    = r_en && (r_state == S_IDLE);
    assign w_req_fire   = req_valid && req_ready;
    assign w_req_beats  = {1'b0, req_len} + c_beat_w'(1);
    assign w_base65     = {4'b0000, req_addr[63:3]};
    // Last word index in 65 bits so a base near 2^61 cannot wrap into range
    assign w_last65     = w_base65 + {{(65 - c_beat_w){1'b0}}, w_req_beats} - 65'd1;
    assign w_range_ok   = (w_last65 < c_mem_words);

    assign w_beats_m1   = r_beats - c_beat_w'(1);
    assign w_fifo_empty = (r_count == '0);
    assign w_pop        = !w_fifo_empty && rdata_ready;
    assign w_push       = r_inflight;
    assign w_popped_nxt = r_popped + {{(c_beat_w - 1){1'b0}}, w_pop};

    // Count the beat already in flight so its push can never overflow the FIFO
    assign w_rd_issue   = (r_state == S_READ) &&
                          ((int'(r_count) + int'(r_inflight)) < FIFO_DEPTH);
    assign w_wr_fire    = (r_state == S_WRITE) && wdata_valid;

    for (genvar k = 0; k < 8; k++) begin : g_mask
        assign w_mask[8*k +: 8] = {8{wstrb[k]}};
    end

    assign wdata_ready  = (r_state == S_WRITE);
    assign mem_enable   = r_en;
    assign mem_r_enable = w_rd_issue;
    assign mem_r_index  = w_rd_issue ? (r_base + 64'(r_issued)) : 64'd0;
    assign mem_w_enable = w_wr_fire;
    assign mem_w_index  = w_wr_fire ? (r_base + 64'(r_written)) : 64'd0;
    assign mem_w_data   = w_wr_fire ? wdata : 64'd0;
    assign mem_w_mask   = w_wr_fire ? w_mask : 64'd0;

    assign rdata_valid  = !w_fifo_empty;
    assign rdata        = w_fifo_empty ? 64'd0 : r_fifo[r_rd_ptr];
    assign rdata_last   = !w_fifo_empty && (r_popped == w_beats_m1);
    assign done         = (r_state == S_RESP);
    assign err          = (r_state == S_RESP) && r_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_fire) begin
                    if (!w_range_ok)    w_state_nxt = S_RESP;
                    else if (req_write) w_state_nxt = S_WRITE;
                    else                w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (w_rd_issue && (r_issued == w_beats_m1)) w_state_nxt = S_RDRAIN;
            end
            S_RDRAIN: begin
                if (w_popped_nxt == r_beats) w_state_nxt = S_RESP;
            end
            S_WRITE: begin
                if (w_wr_fire && (r_written == w_beats_m1)) w_state_nxt = S_RESP;
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_en       <= 1'b0;
            r_base     <= 64'd0;
            r_beats    <= '0;
            r_issued   <= '0;
            r_written  <= '0;
            r_popped   <= '0;
            r_err      <= 1'b0;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_en       <= 1'b1;
            r_inflight <= w_rd_issue;
            if (w_req_fire) begin
                r_base    <= {3'b000, req_addr[63:3]};
                r_beats   <= w_req_beats;
                r_err     <= !w_range_ok;
                r_issued  <= '0;
                r_written <= '0;
                r_popped  <= '0;
            end
            if (w_rd_issue) r_issued  <= r_issued + c_beat_w'(1);
            if (w_wr_fire)  r_written <= r_written + c_beat_w'(1);
            if (w_pop)      r_popped  <= w_popped_nxt;
            if (w_push)     r_wr_ptr  <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)      r_rd_ptr  <= r_rd_ptr + c_ptr_w'(1);
            r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_fifo[r_wr_ptr] <= mem_r_data;
    end

`ifdef MEM_BURST_INITIATOR_ASSERT_EN
    logic              r_chk_stall;
    logic              r_chk_write;
    logic [63:0]       r_chk_addr;
    logic [LEN_W-1:0]  r_chk_len;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_chk_stall <= 1'b0;
            r_chk_write <= 1'b0;
            r_chk_addr  <= 64'd0;
            r_chk_len   <= '0;
        end else begin
            r_chk_stall <= req_valid && !req_ready;
            r_chk_write <= req_write;
            r_chk_addr  <= req_addr;
            r_chk_len   <= req_len;
            if (r_chk_stall && (!req_valid || (req_write != r_chk_write) ||
                                (req_addr != r_chk_addr) || (req_len != r_chk_len)))
                $fatal(1, "mem_burst_initiator: request changed while stalled");
            if (w_push && !w_pop && (int'(r_count) == FIFO_DEPTH))
                $fatal(1, "mem_burst_initiator: read FIFO overflow");
            if (mem_r_enable && (mem_r_index >= MEM_WORDS))
                $fatal(1, "mem_burst_initiator: read index out of range");
            if (mem_w_enable && (mem_w_index >= MEM_WORDS))
                $fatal(1, "mem_burst_initiator: write index out of range");
            if (mem_r_enable && mem_w_enable)
                $fatal(1, "mem_burst_initiator: read and write strobes together");
        end
    end
`else
    // Checks compiled out; datapath and control are unchanged.
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_burst_initiator
// Purpose  : Directed self-checking bench for mem_burst_initiator with a
//            behavioural RAM responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_burst_initiator;

    logic        clock;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr;
    logic [7:0]  req_len;
    logic        wdata_valid, wdata_ready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        rdata_valid, rdata_ready, rdata_last;
    logic [63:0] rdata;
    logic        done, err, mem_enable;
    logic        mem_r_enable, mem_w_enable;
    logic [63:0] mem_r_index, mem_r_data, mem_w_index, mem_w_data, mem_w_mask;

    mem_burst_initiator dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wstrb(wstrb),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .rdata_last(rdata_last), .done(done), .err(err), .mem_enable(mem_enable),
        .mem_r_enable(mem_r_enable), .mem_r_index(mem_r_index), .mem_r_data(mem_r_data),
        .mem_w_enable(mem_w_enable), .mem_w_index(mem_w_index),
        .mem_w_data(mem_w_data), .mem_w_mask(mem_w_mask)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int vectors = 0;
    int miscompares = 0;

    // Responder memory and monitor records
    logic [63:0] tbmem [logic [63:0]];
    logic        pend_r, pend_w;
    logic [63:0] pend_ridx, pend_widx, pend_wdata, pend_wmask;
    logic [63:0] rq[$];
    int          rcyc[$];
    logic [63:0] wq_idx[$], wq_mask[$];
    int          wcyc[$];
    logic [63:0] popq[$];
    logic        lastq[$];
    int          popcyc[$];
    int          done_cnt, done_cyc, both_cnt, out_cnt, max_out, cyc_n;
    logic        done_err;

    function automatic logic [63:0] rdmem(input logic [63:0] idx);
        return tbmem.exists(idx) ? tbmem[idx] : 64'd0;
    endfunction

    initial begin
        pend_r = 1'b0; pend_w = 1'b0; pend_ridx = '0; pend_widx = '0;
        pend_wdata = '0; pend_wmask = '0; mem_r_data = '0;
        done_cnt = 0; done_cyc = 0; both_cnt = 0; out_cnt = 0; max_out = 0;
        cyc_n = 0; done_err = 1'b0;
    end

    always @(negedge clock) begin
        pend_r = mem_r_enable; pend_ridx = mem_r_index;
        pend_w = mem_w_enable; pend_widx = mem_w_index;
        pend_wdata = mem_w_data; pend_wmask = mem_w_mask;
        if (mem_r_enable) begin
            rq.push_back(mem_r_index); rcyc.push_back(cyc_n); out_cnt++;
        end
        if (mem_w_enable) begin
            wq_idx.push_back(mem_w_index); wq_mask.push_back(mem_w_mask); wcyc.push_back(cyc_n);
        end
        if (mem_r_enable && mem_w_enable) both_cnt++;
        if (rdata_valid && rdata_ready) begin
            popq.push_back(rdata); lastq.push_back(rdata_last); popcyc.push_back(cyc_n);
            out_cnt--;
        end
        if (out_cnt > max_out) max_out = out_cnt;
        if (done) begin
            done_cnt++; done_cyc = cyc_n; done_err = err;
        end
        cyc_n++;
    end

    always @(posedge clock) begin
        if (pend_r) mem_r_data <= rdmem(pend_ridx);
        if (pend_w) tbmem[pend_widx] = (rdmem(pend_widx) & ~pend_wmask) | (pend_wdata & pend_wmask);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        rq.delete(); rcyc.delete(); wq_idx.delete(); wq_mask.delete(); wcyc.delete();
        popq.delete(); lastq.delete(); popcyc.delete();
        done_cnt = 0; done_cyc = 0; done_err = 1'b0; out_cnt = 0; max_out = 0;
    endtask

    task automatic start_req(input logic wr, input logic [63:0] addr, input logic [7:0] len);
        int n = 0;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len;
        #1;
        while (!req_ready && n < 20) begin
            cyc(); #1; n++;
        end
        chk("req_accept", {63'd0, req_ready}, 64'd1);
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            cyc(); n++;
        end
        chk("done_seen", {63'd0, (done_cnt != 0)}, 64'd1);
        cyc(); cyc();
    endtask

    initial begin
        int bad;
        int n;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wdata_valid = 1'b0; wdata = '0; wstrb = '0; rdata_ready = 1'b0;
        for (int i = 0; i < 64; i++) tbmem[64'(i)] = 64'(i);
        tbmem[64'h200] = 64'h1111_2222_3333_4444;

        // Reset state
        cyc(); cyc();
        chk("rst_mem_enable", {63'd0, mem_enable}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        reset = 1'b0;
        cyc(); cyc();
        chk("run_mem_enable", {63'd0, mem_enable}, 64'd1);
        chk("idle_req_ready", {63'd0, req_ready}, 64'd1);

        // Write beats outside WRITE are ignored
        wdata_valid = 1'b1; wdata = 64'hFFFF; wstrb = 8'hFF;
        #1;
        chk("idle_wdata_ready", {63'd0, wdata_ready}, 64'd0);
        chk("idle_w_enable", {63'd0, mem_w_enable}, 64'd0);
        wdata_valid = 1'b0;
        cyc();

        // 4-beat read at 0x80
        clr(); rdata_ready = 1'b1;
        start_req(1'b0, 64'h80, 8'd3);
        wait_done(40);
        chk("rd4_nissue", 64'(rq.size()), 64'd4);
        chk("rd4_idx0", rq[0], 64'h10);
        chk("rd4_idx3", rq[3], 64'h13);
        chk("rd4_consec", 64'(rcyc[3] - rcyc[0]), 64'd3);
        chk("rd4_npop", 64'(popq.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("rd4_data", popq[i], 64'h10 + 64'(i));
        chk("rd4_last", {60'd0, lastq[3], lastq[2], lastq[1], lastq[0]}, 64'h8);
        chk("rd4_done_lat", 64'(done_cyc - popcyc[3]), 64'd1);
        chk("rd4_err", {63'd0, done_err}, 64'd0);

        // 2-beat masked write at 0x1000 then read back
        clr();
        start_req(1'b1, 64'h1000, 8'd1);
        wdata_valid = 1'b1; wdata = 64'hDEAD_BEEF_CAFE_F00D; wstrb = 8'h0F;
        cyc();
        wdata = 64'h0123_4567_89AB_CDEF; wstrb = 8'hFF;
        cyc();
        wdata_valid = 1'b0;
        wait_done(10);
        chk("wr2_n", 64'(wq_idx.size()), 64'd2);
        chk("wr2_idx0", wq_idx[0], 64'h200);
        chk("wr2_mask0", wq_mask[0], 64'h0000_0000_FFFF_FFFF);
        chk("wr2_idx1", wq_idx[1], 64'h201);
        chk("wr2_mask1", wq_mask[1], 64'hFFFF_FFFF_FFFF_FFFF);
        clr();
        start_req(1'b0, 64'h1000, 8'd1);
        wait_done(20);
        chk("rb_data0", popq[0], 64'h1111_2222_CAFE_F00D);
        chk("rb_data1", popq[1], 64'h0123_4567_89AB_CDEF);

        // 16-beat read with rdata_ready 1 on / 2 off
        clr(); rdata_ready = 1'b0;
        start_req(1'b0, 64'h0, 8'd15);
        n = 0;
        while (done_cnt == 0 && n < 300) begin
            rdata_ready = (n % 3 == 0);
            cyc(); n++;
        end
        chk("rd16_done", {63'd0, (done_cnt != 0)}, 64'd1);
        rdata_ready = 1'b1;
        cyc();
        chk("rd16_npop", 64'(popq.size()), 64'd16);
        bad = 0;
        for (int i = 0; i < 16; i++) if (popq[i] !== 64'(i)) bad++;
        chk("rd16_order", 64'(bad), 64'd0);
        chk("rd16_outstanding", {63'd0, (max_out <= 4)}, 64'd1);

        // Range boundary: ends on the last word, then one past it
        clr();
        start_req(1'b0, 64'h0_FFFF_FFF0, 8'd1);
        wait_done(20);
        chk("edge_ok_n", 64'(rq.size()), 64'd2);
        chk("edge_ok_idx", rq[1], 64'h1FFF_FFFF);
        chk("edge_ok_err", {63'd0, done_err}, 64'd0);
        clr();
        start_req(1'b0, 64'h0_FFFF_FFF0, 8'd2);
        wait_done(10);
        chk("edge_bad_n", 64'(rq.size() + wq_idx.size()), 64'd0);
        chk("edge_bad_err", {63'd0, done_err}, 64'd1);
        chk("edge_bad_done", 64'(done_cnt), 64'd1);

        // Reset in the middle of an 8-beat read
        clr(); rdata_ready = 1'b0;
        start_req(1'b0, 64'h80, 8'd7);
        cyc(); cyc(); cyc();
        reset = 1'b1;
        cyc();
        chk("mid_rst_outs", {req_ready, wdata_ready, rdata_valid, rdata_last, done, err,
                             mem_enable, mem_r_enable, mem_w_enable}, 64'd0);
        chk("mid_rst_buses", rdata | mem_r_index | mem_w_index | mem_w_data | mem_w_mask, 64'd0);
        reset = 1'b0;
        clr(); rdata_ready = 1'b1;
        cyc(); cyc(); cyc();
        chk("post_rst_quiet", 64'(rq.size() + done_cnt + popq.size()), 64'd0);
        start_req(1'b0, 64'h80, 8'd1);
        wait_done(20);
        chk("post_rst_d0", popq[0], 64'h10);
        chk("post_rst_d1", popq[1], 64'h11);
        chk("post_rst_last", {62'd0, lastq[1], lastq[0]}, 64'h2);

        // 256-beat continuous write
        clr();
        start_req(1'b1, 64'h8000, 8'd255);
        wdata_valid = 1'b1; wstrb = 8'hFF;
        n = 0;
        while (done_cnt == 0 && n < 300) begin
            wdata = 64'(n);
            cyc(); n++;
        end
        wdata_valid = 1'b0;
        cyc(); cyc(); cyc();
        chk("wr256_n", 64'(wq_idx.size()), 64'd256);
        bad = 0;
        for (int i = 0; i < wq_idx.size(); i++) begin
            if (wq_idx[i] !== 64'h1000 + 64'(i)) bad++;
            if (i > 0 && wcyc[i] != wcyc[i-1] + 1) bad++;
        end
        chk("wr256_seq", 64'(bad), 64'd0);
        chk("wr256_done", 64'(done_cnt), 64'd1);
        chk("no_dual_strobe", 64'(both_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_burst_initiator.md
Name: mem_burst_initiator

Overview:
- Initiator side of the word-indexed memory RW port (r_enable/r_index/r_data, w_enable/w_index/w_data/w_mask, enable) that the simulation RAM helper implements.
- Accepts byte-addressed burst requests on a valid/ready front end and walks the burst one 64-bit word per cycle.
- Returns read data through a small skid FIFO with backpressure.
- Used by checkpoint restore/dump and test harness DMA paths to drive the RAM helper without hand-sequenced index logic.

Parameters:
- LEN_W, 8, width of req_len; burst beats = req_len+1 (1..256).
- FIFO_DEPTH, 4, read-response FIFO entries, power of two, >=2.
- MEM_WORDS, 536870912, number of 64-bit words the responder backs (4 banks x 2^27); word index must be < MEM_WORDS.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  burst request valid.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1=write burst, 0=read burst.
- req_addr  in  64  byte address; bits [2:0] ignored.
- req_len  in  LEN_W  beats minus one.
- wdata_valid  in  1  write beat valid.
- wdata_ready  out  1  write beat accepted this cycle.
- wdata  in  64  write beat data.
- wstrb  in  8  byte strobes; expanded to a 64-bit bit-mask.
- rdata_valid  out  1  read beat available.
- rdata_ready  in  1  consumer accepts read beat.
- rdata  out  64  read beat data.
- rdata_last  out  1  final beat of the burst.
- done  out  1  one-cycle pulse at burst completion.
- err  out  1  qualifies done: burst rejected as out of range.
- mem_enable  out  1  drives the responder enable; high whenever not in reset.
- mem_r_enable  out  1  read strobe.
- mem_r_index  out  64  read word index.
- mem_r_data  in  64  read data, valid exactly one cycle after mem_r_enable.
- mem_w_enable  out  1  write strobe.
- mem_w_index  out  64  write word index.
- mem_w_data  out  64  write data.
- mem_w_mask  out  64  bit mask; byte k = {8{wstrb[k]}}.

Behaviour:
- Reset: all outputs 0 (mem_enable 0 during reset, 1 from the first cycle after reset deasserts). FSM returns to IDLE, FIFO empties, counters clear. Reset mid-burst aborts immediately, with no further mem strobes and no done pulse.
- States: IDLE, READ, RDRAIN, WRITE, RESP.
- IDLE:
  - req_ready=1. Handshake (req_valid & req_ready) latches base=req_addr[63:3] and beats=req_len+1.
  - Range check: base+beats-1 is computed in 65 bits and must be < MEM_WORDS.
  - Check fails -> RESP with err=1; no mem access at all.
  - Check passes -> READ or WRITE.
- READ:
  - Each cycle, issue mem_r_enable with mem_r_index=base+issued, only if fifo_count + inflight < FIFO_DEPTH. inflight is 0 or 1 (the previous cycle's issue).
  - Returned data is pushed into the FIFO the cycle after issue.
  - After the last issue -> RDRAIN.
- RDRAIN: wait until all beats have been popped by the consumer -> RESP.
- rdata_valid = FIFO non-empty. rdata_last is high on the beat whose pop count equals beats-1. A pop and a push in the same cycle are both honoured. Peak throughput is 1 beat/cycle with rdata_ready held high.
- WRITE:
  - wdata_ready=1 in this state.
  - On each wdata handshake, in the same cycle (combinational), assert mem_w_enable with mem_w_index=base+written, mem_w_data=wdata, mem_w_mask=expanded wstrb.
  - After the last beat -> RESP.
  - wstrb=0 still issues the strobe, with mask 0.
- RESP: done=1 for one cycle; err held for that cycle only; -> IDLE. The next request is accepted in IDLE, so there is a minimum of one idle cycle between bursts.
- mem_r_enable and mem_w_enable are never asserted in the same cycle.
- Index arithmetic is 64-bit unsigned. A burst ending exactly at MEM_WORDS-1 is legal; one word beyond it sets err.
- wdata_valid in any state other than WRITE is ignored, and wdata_ready stays 0.

Optional Feature:
- MEM_BURST_INITIATOR_ASSERT_EN defined: simulation checks that call $fatal(1, ...) on any of:
  - req_* changing while req_valid & !req_ready;
  - rdata_ready dropping a beat (FIFO overflow push);
  - mem_r_index or mem_w_index >= MEM_WORDS on a strobe;
  - both strobes in the same cycle.
- Undefined: no checks; the logic is otherwise identical.

Test Plan:
- Read 4 beats at req_addr=0x80, rdata_ready=1, responder preloaded with word i = i -> mem_r_index 0x10..0x13 on consecutive cycles; rdata 0x10..0x13; rdata_last on the 4th beat; done 1 cycle after the last pop; err=0.
- Write 2 beats at 0x1000 with wstrb=0x0F then 0xFF -> mem_w_index 0x200 with mask 0x00000000FFFFFFFF, then 0x201 with mask all-ones; a read-back burst returns the merged data.
- Read 16 beats with rdata_ready toggling 1 cycle on, 2 off -> outstanding reads never exceed FIFO_DEPTH; all 16 beats arrive in order with no loss.
- req_addr=(MEM_WORDS-2)*8, req_len=1 -> passes, 2 accesses. Same request with req_len=2 -> no mem strobe; done=1 with err=1.
- Reset asserted 3 cycles into a 8-beat read -> next cycle all outputs 0, FIFO empty; a fresh burst after reset completes normally.
- req_len=255 write with wdata_valid continuous -> 256 consecutive mem_w_enable cycles; indices increment with no gaps; a single done pulse.
